vend_controller: RTL and testbench

//  Sequencing controller for the coin-operated vending path. Accepts nickel/dime/quarter

---
 rtl/vend_controller.sv | 113 +++++++++++
 tb/tb_vend_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Coin-operated vending sequencer: accumulates nickel/dime/quarter credit, requests a
// dispense at PRICE, then returns leftover credit one nickel per change handshake.
module vend_controller #(
  parameter int unsigned PRICE      = 15,
  parameter int unsigned MAX_CREDIT = 50,
  parameter int unsigned CW         = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          coin_n,
  input  logic          coin_d,
  input  logic          coin_q,
  input  logic          cancel,
  input  logic          dispense_ack,
  input  logic          change_ack,
  output logic [CW-1:0] credit,
  output logic          dispense_req,
  output logic          change_valid,
  output logic          coin_reject,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_CREDIT);
  localparam logic [CW-1:0] NICKEL_C  = CW'(5);
  localparam logic [CW-1:0] DIME_C    = CW'(10);
  localparam logic [CW-1:0] QUARTER_C = CW'(25);

  state_t        state;
  logic          coin_any;
  logic          coin_multi;
  logic          coin_ok;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] credit_sum;

  // Coin decode: a coin is accepted only if it is the sole pulse and fits under the cap.
  always_comb begin
    coin_val = '0;
    if (coin_q)      coin_val = QUARTER_C;
    else if (coin_d) coin_val = DIME_C;
    else if (coin_n) coin_val = NICKEL_C;
    coin_any   = coin_n | coin_d | coin_q;
    coin_multi = (coin_n & coin_d) | (coin_n & coin_q) | (coin_d & coin_q);
    credit_sum = credit + coin_val;
    coin_ok    = coin_any & ~coin_multi & (credit_sum <= MAX_C);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      credit       <= '0;
      dispense_req <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (coin_ok) begin
            credit <= credit_sum;
            if (credit_sum >= PRICE_C) begin
              state        <= DISPENSE;
              dispense_req <= 1'b1;
              busy         <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end else begin
            coin_reject <= coin_any;
            // Cancel only refunds when no coin was credited in the same cycle.
            if (cancel && state == COLLECT) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_any;
          if (dispense_ack) begin
            assert (credit >= PRICE_C);
            credit       <= credit - PRICE_C;
            dispense_req <= 1'b0;
            if (credit == PRICE_C) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state        <= CHANGE;
              change_valid <= 1'b1;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_any;
          if (change_ack) begin
            assert (credit >= NICKEL_C);
            credit <= credit - NICKEL_C;
            if (credit == NICKEL_C) begin
              state        <= IDLE;
              change_valid <= 1'b0;
              busy         <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: default PRICE=15 instance plus a PRICE=40 instance.
module tb_vend_controller;

  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reset_n1;
  logic          coin_n, coin_d, coin_q, cancel, dispense_ack, change_ack;
  logic [CW-1:0] credit, credit1;
  logic          dispense_req, change_valid, coin_reject, busy;
  logic          dispense_req1, change_valid1, coin_reject1, busy1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vend_controller #(.PRICE(15), .MAX_CREDIT(50), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q), .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .credit(credit), .dispense_req(dispense_req), .change_valid(change_valid),
    .coin_reject(coin_reject), .busy(busy)
  );

  vend_controller #(.PRICE(40), .MAX_CREDIT(50), .CW(CW)) dut40 (
    .clk(clk), .reset_n(reset_n1),
    .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q), .cancel(cancel),
    .dispense_ack(dispense_ack), .change_ack(change_ack),
    .credit(credit1), .dispense_req(dispense_req1), .change_valid(change_valid1),
    .coin_reject(coin_reject1), .busy(busy1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the default instance: credit, dispense_req, change_valid, busy, coin_reject.
  task automatic chk5(input string tag, input int c, input int dr, input int cv,
                      input int b, input int cr);
    chk({tag, ".credit"}, int'(credit), c);
    chk({tag, ".dispense_req"}, int'(dispense_req), dr);
    chk({tag, ".change_valid"}, int'(change_valid), cv);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".coin_reject"}, int'(coin_reject), cr);
  endtask

  task automatic chk40(input string tag, input int c, input int dr, input int b,
                       input int cr);
    chk({tag, ".credit"}, int'(credit1), c);
    chk({tag, ".dispense_req"}, int'(dispense_req1), dr);
    chk({tag, ".busy"}, int'(busy1), b);
    chk({tag, ".coin_reject"}, int'(coin_reject1), cr);
  endtask

  initial begin
    reset_n = 1'b0; reset_n1 = 1'b0;
    coin_n = 0; coin_d = 0; coin_q = 0; cancel = 0; dispense_ack = 0; change_ack = 0;
    cyc(); cyc();
    chk5("reset", 0, 0, 0, 0, 0);
    chk40("reset40", 0, 0, 0, 0);
    reset_n = 1'b1;

    // 1: three nickels reach price exactly, ack returns to IDLE with no change
    coin_n = 1; cyc(); chk5("t1.n1", 5, 0, 0, 0, 0);
    cyc(); chk5("t1.n2", 10, 0, 0, 0, 0);
    cyc(); coin_n = 0; chk5("t1.n3", 15, 1, 0, 1, 0);
    cyc(); chk5("t1.hold", 15, 1, 0, 1, 0);
    dispense_ack = 1; cyc(); dispense_ack = 0; chk5("t1.ack", 0, 0, 0, 0, 0);

    // 2: quarter, dispense, then two back-to-back nickels of change
    coin_q = 1; cyc(); coin_q = 0; chk5("t2.q", 25, 1, 0, 1, 0);
    dispense_ack = 1; cyc(); dispense_ack = 0; chk5("t2.ack", 10, 0, 1, 1, 0);
    change_ack = 1; cyc(); chk5("t2.c1", 5, 0, 1, 1, 0);
    cyc(); change_ack = 0; chk5("t2.c2", 0, 0, 0, 0, 0);

    // stray acks in IDLE are ignored
    dispense_ack = 1; change_ack = 1; cyc(); dispense_ack = 0; change_ack = 0;
    chk5("idle.stray_ack", 0, 0, 0, 0, 0);

    // 3: dime then cancel refunds without dispensing
    coin_d = 1; cyc(); coin_d = 0; chk5("t3.d", 10, 0, 0, 0, 0);
    cancel = 1; cyc(); cancel = 0; chk5("t3.cancel", 10, 0, 1, 1, 0);
    change_ack = 1; cyc(); chk5("t3.c1", 5, 0, 1, 1, 0);
    cyc(); change_ack = 0; chk5("t3.c2", 0, 0, 0, 0, 0);

    // cancel and accepted coin together: coin wins
    coin_n = 1; cyc(); coin_n = 0; chk5("t3b.n", 5, 0, 0, 0, 0);
    coin_n = 1; cancel = 1; cyc(); coin_n = 0; cancel = 0; chk5("t3b.n_cancel", 10, 0, 0, 0, 0);
    coin_n = 1; cyc(); coin_n = 0; chk5("t3b.n3", 15, 1, 0, 1, 0);
    dispense_ack = 1; cyc(); dispense_ack = 0; chk5("t3b.ack", 0, 0, 0, 0, 0);

    // 4: simultaneous coins rejected; coin during DISPENSE rejected
    coin_n = 1; coin_d = 1; cyc(); coin_n = 0; coin_d = 0; chk5("t4.nd", 0, 0, 0, 0, 1);
    cyc(); chk5("t4.nd_after", 0, 0, 0, 0, 0);
    coin_q = 1; cyc(); chk5("t4.q", 25, 1, 0, 1, 0);
    cyc(); coin_q = 0; chk5("t4.q_disp", 25, 1, 0, 1, 1);
    cyc(); chk5("t4.q_disp_after", 25, 1, 0, 1, 0);
    dispense_ack = 1; cyc(); dispense_ack = 0; chk5("t4.ack", 10, 0, 1, 1, 0);
    coin_n = 1; cyc(); coin_n = 0; chk5("t4.n_change", 10, 0, 1, 1, 1);

    // 6: reset mid-CHANGE with credit 10 drops everything
    reset_n = 0; cyc(); reset_n = 1; chk5("t6.reset", 0, 0, 0, 0, 0);
    coin_n = 1; cyc(); coin_n = 0; chk5("t6.after", 5, 0, 0, 0, 0);

    // over-limit in COLLECT on default instance: 5+25+25 > 50 is impossible pre-dispense,
    // so exercise it on the PRICE=40 instance below.
    reset_n = 0;
    reset_n1 = 1;

    // 5: PRICE=40
    coin_q = 1; cyc(); coin_q = 0; chk40("t5.q", 25, 0, 0, 0);
    coin_d = 1; cyc(); coin_d = 0; chk40("t5.d", 35, 0, 0, 0);
    coin_q = 1; cyc(); coin_q = 0; chk40("t5.q_over", 35, 0, 0, 1);
    coin_n = 1; cyc(); coin_n = 0; chk40("t5.n", 40, 1, 1, 0);
    dispense_ack = 1; cyc(); dispense_ack = 0; chk40("t5.ack", 0, 0, 0, 0);
    chk("t5.cv", int'(change_valid1), 0);
    chk("t5.other_held", int'(credit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
